// File: rtl/dmem_responder_if.sv
// Request/response bus between a pipeline memory stage and the data-memory responder.
interface dmem_responder_if #(
  parameter int WIDTH = 32
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_write_i;
  logic [WIDTH-1:0] req_addr_i;
  logic [WIDTH-1:0] req_wdata_i;
  logic [2:0]       req_funct3_i;
  logic             rsp_valid_o;
  logic [WIDTH-1:0] rsp_rdata_o;
  logic             rsp_err_o;
  logic             busy_o;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_funct3_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_funct3_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: RISC-V byte/half/word loads and stores,
// with alignment, range and funct3 checks. Byte-lane decode assumes WIDTH = 32.
module dmem_responder #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);
  // state | meaning
  // IDLE  | no transaction, ready for a request
  // WAIT  | request accepted, counting down to the response edge
  // RESP  | response strobe visible, a new request may be accepted
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int DEPTH  = 1 << (ADDR_BITS - 2);
  localparam int NBYTES = WIDTH / 8;

  state_t                 r_state, w_state_nxt;
  logic [2:0]             r_cnt, w_cnt_nxt;
  logic                   r_write;
  logic [WIDTH-1:0]       r_addr, r_wdata;
  logic [2:0]             r_funct3;
  logic                   r_rsp_valid, r_rsp_err;
  logic [WIDTH-1:0]       r_rsp_rdata;
  logic [WIDTH-1:0]       r_mem [DEPTH];

  logic                   w_accept, w_fire, w_direct;
  logic                   w_write, w_err;
  logic [WIDTH-1:0]       w_addr, w_wdata, w_word, w_shift, w_rdata, w_wlane;
  logic [2:0]             w_funct3;
  logic [1:0]             w_off;
  logic [ADDR_BITS-3:0]   w_idx;
  logic [NBYTES-1:0]      w_be;

  assign bus.req_ready_o = (r_state != WAIT) && !rst;
  assign bus.busy_o      = (r_state == WAIT);
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_err_o   = r_rsp_err;
  assign w_accept        = bus.req_valid_i && bus.req_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fire      = 1'b0;
    case (r_state)
      IDLE, RESP: begin
        w_state_nxt = IDLE;
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
            w_fire      = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = 3'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_state_nxt = RESP;
          w_fire      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
    end else if (w_accept) begin
      r_write  <= bus.req_write_i;
      r_addr   <= bus.req_addr_i;
      r_wdata  <= bus.req_wdata_i;
      r_funct3 <= bus.req_funct3_i;
    end
  end

  // With LATENCY=1 the response edge is the acceptance edge, so use the live request.
  assign w_direct = (r_state != WAIT);
  assign w_write  = w_direct ? bus.req_write_i  : r_write;
  assign w_addr   = w_direct ? bus.req_addr_i   : r_addr;
  assign w_wdata  = w_direct ? bus.req_wdata_i  : r_wdata;
  assign w_funct3 = w_direct ? bus.req_funct3_i : r_funct3;
  assign w_off    = w_addr[1:0];
  assign w_idx    = w_addr[ADDR_BITS-1:2];

  always_comb begin
    w_err = |w_addr[WIDTH-1:ADDR_BITS];
    case (w_funct3)
      3'b000:  w_err = w_err;
      3'b100:  w_err = w_err | w_write;
      3'b001:  w_err = w_err | w_off[0];
      3'b101:  w_err = w_err | w_off[0] | w_write;
      3'b010:  w_err = w_err | (|w_off);
      default: w_err = 1'b1;
    endcase
  end

  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_off, 3'b000};

  always_comb begin
    w_rdata = '0;
    case (w_funct3)
      3'b000:  w_rdata = {{(WIDTH-8){w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_rdata = {{(WIDTH-16){w_shift[15]}}, w_shift[15:0]};
      3'b010:  w_rdata = w_shift;
      3'b100:  w_rdata = {{(WIDTH-8){1'b0}}, w_shift[7:0]};
      3'b101:  w_rdata = {{(WIDTH-16){1'b0}}, w_shift[15:0]};
      default: w_rdata = '0;
    endcase
  end

  always_comb begin
    w_wlane = '0;
    w_be    = '0;
    case (w_funct3[1:0])
      2'b00: begin
        w_wlane = {NBYTES{w_wdata[7:0]}};
        w_be    = NBYTES'(1) << w_off;
      end
      2'b01: begin
        w_wlane = {(NBYTES/2){w_wdata[15:0]}};
        w_be    = NBYTES'(3) << {w_off[1], 1'b0};
      end
      2'b10: begin
        w_wlane = w_wdata;
        w_be    = '1;
      end
      default: begin
        w_wlane = '0;
        w_be    = '0;
      end
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_fire && w_write && !w_err) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wlane[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_fire;
      r_rsp_err   <= w_fire && w_err;
      r_rsp_rdata <= (w_fire && !w_write && !w_err) ? w_rdata : '0;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: LATENCY=2 instance for directed/random
// traffic and reset abort, LATENCY=1 instance for back-to-back streaming.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if #(.WIDTH(32)) b2();
  dmem_responder_if #(.WIDTH(32)) b1();

  dmem_responder #(.WIDTH(32), .ADDR_BITS(12), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(b2)
  );
  dmem_responder #(.WIDTH(32), .ADDR_BITS(12), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] mdl [0:1023];

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  // Reference model: applies one request to the word array and predicts the response.
  task automatic model(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int sh;
    logic [31:0] w, v, m;
    er = (a >= 32'h1000) || (f3 == 3) || (f3 == 6) || (f3 == 7) ||
         (wr && (f3 == 4 || f3 == 5)) ||
         ((f3 == 1 || f3 == 5) && (a % 2 != 0)) || (f3 == 2 && (a % 4 != 0));
    rd = 32'h0;
    if (er) return;
    sh = 8 * int'(a % 4);
    w  = mdl[a / 4];
    if (wr) begin
      if (f3 == 0) begin
        m = 32'hFF << sh;
        w = (w & ~m) | ((wd & 32'hFF) << sh);
      end else if (f3 == 1) begin
        m = 32'hFFFF << sh;
        w = (w & ~m) | ((wd & 32'hFFFF) << sh);
      end else begin
        w = wd;
      end
      mdl[a / 4] = w;
    end else begin
      v = w >> sh;
      case (f3)
        3'd0: rd = (v & 32'hFF) | (((v & 32'h80) != 0) ? 32'hFFFF_FF00 : 32'h0);
        3'd1: rd = (v & 32'hFFFF) | (((v & 32'h8000) != 0) ? 32'hFFFF_0000 : 32'h0);
        3'd2: rd = w;
        3'd4: rd = v & 32'hFF;
        default: rd = v & 32'hFFFF;
      endcase
    end
  endtask

  // Drives one request into the LATENCY=2 instance and captures its response.
  task automatic txn2(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, output logic [31:0] rd, output logic er,
                      output int lat, output logic one_shot);
    int g = 0;
    @(negedge clk);
    while (b2.req_ready_o !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    b2.req_valid_i  = 1'b1;
    b2.req_write_i  = wr;
    b2.req_addr_i   = a;
    b2.req_wdata_i  = wd;
    b2.req_funct3_i = f3;
    @(posedge clk);
    #1;
    b2.req_valid_i  = 1'b0;
    b2.req_write_i  = 1'($urandom);
    b2.req_addr_i   = $urandom;
    b2.req_wdata_i  = $urandom;
    b2.req_funct3_i = 3'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (b2.rsp_valid_o !== 1'b1 && lat < 20);
    if (lat >= 20) lat = -1;
    rd = b2.rsp_rdata_o;
    er = b2.rsp_err_o;
    @(negedge clk);
    one_shot = (b2.rsp_valid_o === 1'b0) && (b2.rsp_rdata_o === 32'h0) && (b2.rsp_err_o === 1'b0);
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (b2.rsp_valid_o !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", b2.rsp_valid_o); else n_pass++;
    n_checks++; if (b2.busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", b2.busy_o); else n_pass++;
    n_checks++; if (b2.rsp_err_o !== 1'b0) $display("FAIL reset_err got %b want 0", b2.rsp_err_o); else n_pass++;
    n_checks++; if (b2.rsp_rdata_o !== 32'h0) $display("FAIL reset_rdata got %h want 0", b2.rsp_rdata_o); else n_pass++;
    n_checks++; if (b1.rsp_valid_o !== 1'b0) $display("FAIL reset_rsp_valid_l1 got %b want 0", b1.rsp_valid_o); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (b2.req_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", b2.req_ready_o); else n_pass++;
    n_checks++; if (b1.req_ready_o !== 1'b1) $display("FAIL reset_ready_l1 got %b want 1", b1.req_ready_o); else n_pass++;
  endtask

  task automatic test_directed();
    vec_t dv [14];
    logic [31:0] rd, mrd;
    logic er, mer, os;
    int lat;
    dv[0]  = '{1'b1, 32'h10,   32'hDEAD_BEEF, 3'b010, 32'h0,         1'b0};
    dv[1]  = '{1'b0, 32'h10,   32'h0,         3'b010, 32'hDEAD_BEEF, 1'b0};
    dv[2]  = '{1'b0, 32'h13,   32'h0,         3'b000, 32'hFFFF_FFDE, 1'b0};
    dv[3]  = '{1'b0, 32'h13,   32'h0,         3'b100, 32'h0000_00DE, 1'b0};
    dv[4]  = '{1'b0, 32'h10,   32'h0,         3'b001, 32'hFFFF_BEEF, 1'b0};
    dv[5]  = '{1'b0, 32'h12,   32'h0,         3'b101, 32'h0000_DEAD, 1'b0};
    dv[6]  = '{1'b1, 32'h11,   32'h0000_0055, 3'b000, 32'h0,         1'b0};
    dv[7]  = '{1'b0, 32'h10,   32'h0,         3'b010, 32'hDEAD_55EF, 1'b0};
    dv[8]  = '{1'b0, 32'h12,   32'h0,         3'b010, 32'h0,         1'b1};
    dv[9]  = '{1'b1, 32'h11,   32'h0000_AAAA, 3'b001, 32'h0,         1'b1};
    dv[10] = '{1'b0, 32'h1000, 32'h0,         3'b010, 32'h0,         1'b1};
    dv[11] = '{1'b0, 32'h10,   32'h0,         3'b011, 32'h0,         1'b1};
    dv[12] = '{1'b1, 32'h10,   32'h0000_0077, 3'b100, 32'h0,         1'b1};
    dv[13] = '{1'b0, 32'h10,   32'h0,         3'b010, 32'hDEAD_55EF, 1'b0};
    for (int i = 0; i < 14; i++) begin
      txn2(dv[i].wr, dv[i].a, dv[i].wd, dv[i].f3, rd, er, lat, os);
      model(dv[i].wr, dv[i].a, dv[i].wd, dv[i].f3, mrd, mer);
      n_checks++; if (lat != 2) $display("FAIL dir%0d_latency got %0d want 2", i, lat); else n_pass++;
      n_checks++; if (rd !== dv[i].rd) $display("FAIL dir%0d_rdata got %h want %h", i, rd, dv[i].rd); else n_pass++;
      n_checks++; if (er !== dv[i].er) $display("FAIL dir%0d_err got %b want %b", i, er, dv[i].er); else n_pass++;
      n_checks++; if (os !== 1'b1) $display("FAIL dir%0d_one_cycle_strobe got %b want 1", i, os); else n_pass++;
    end
  endtask

  task automatic test_busy_ready();
    @(negedge clk);
    b2.req_valid_i  = 1'b1;
    b2.req_write_i  = 1'b0;
    b2.req_addr_i   = 32'h10;
    b2.req_funct3_i = 3'b010;
    @(posedge clk);
    #1 b2.req_valid_i = 1'b0;
    @(negedge clk);
    n_checks++; if (b2.busy_o !== 1'b1) $display("FAIL wait_busy got %b want 1", b2.busy_o); else n_pass++;
    n_checks++; if (b2.req_ready_o !== 1'b0) $display("FAIL wait_ready got %b want 0", b2.req_ready_o); else n_pass++;
    n_checks++; if (b2.rsp_valid_o !== 1'b0) $display("FAIL wait_rsp_valid got %b want 0", b2.rsp_valid_o); else n_pass++;
    @(negedge clk);
    n_checks++; if (b2.rsp_valid_o !== 1'b1) $display("FAIL resp_valid got %b want 1", b2.rsp_valid_o); else n_pass++;
    n_checks++; if (b2.busy_o !== 1'b0) $display("FAIL resp_busy got %b want 0", b2.busy_o); else n_pass++;
    n_checks++; if (b2.req_ready_o !== 1'b1) $display("FAIL resp_ready got %b want 1", b2.req_ready_o); else n_pass++;
    n_checks++; if (b2.rsp_rdata_o !== 32'hDEAD_55EF) $display("FAIL resp_rdata got %h want deaD55ef", b2.rsp_rdata_o); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0] legal [5];
    logic [2:0] illegal [3];
    logic [31:0] a, wd, rd, mrd;
    logic [2:0] f3;
    logic wr, er, mer, os;
    int lat, r;
    legal   = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    illegal = '{3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      txn2(1'b1, 32'(i * 4), wd, 3'b010, rd, er, lat, os);
      model(1'b1, 32'(i * 4), wd, 3'b010, mrd, mer);
      n_checks++; if (er !== 1'b0) $display("FAIL rinit%0d_err got %b want 0", i, er); else n_pass++;
    end
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom);
      wd = $urandom;
      r  = int'($urandom % 16);
      f3 = (r < 13) ? legal[r % 5] : illegal[r - 13];
      a  = 32'(($urandom % 8) * 4);
      if ($urandom % 2 == 0) a = a + 32'($urandom % 4);
      if ($urandom % 10 == 0) a = a | 32'h1000;
      model(wr, a, wd, f3, mrd, mer);
      txn2(wr, a, wd, f3, rd, er, lat, os);
      n_checks++; if (lat != 2) $display("FAIL rnd%0d_latency got %0d want 2", i, lat); else n_pass++;
      n_checks++; if (rd !== mrd) $display("FAIL rnd%0d_rdata wr=%b a=%h f3=%b got %h want %h", i, wr, a, f3, rd, mrd); else n_pass++;
      n_checks++; if (er !== mer) $display("FAIL rnd%0d_err wr=%b a=%h f3=%b got %b want %b", i, wr, a, f3, er, mer); else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, mrd;
    logic er, mer, os, seen;
    int lat;
    txn2(1'b1, 32'h20, 32'hCAFE_F00D, 3'b010, rd, er, lat, os);
    model(1'b1, 32'h20, 32'hCAFE_F00D, 3'b010, mrd, mer);
    @(negedge clk);
    b2.req_valid_i  = 1'b1;
    b2.req_write_i  = 1'b1;
    b2.req_addr_i   = 32'h20;
    b2.req_wdata_i  = 32'h1234_5678;
    b2.req_funct3_i = 3'b010;
    @(posedge clk);
    #1 b2.req_valid_i = 1'b0;
    @(negedge clk);
    n_checks++; if (b2.busy_o !== 1'b1) $display("FAIL abort_busy_before got %b want 1", b2.busy_o); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (b2.busy_o !== 1'b0) $display("FAIL abort_busy_in_reset got %b want 0", b2.busy_o); else n_pass++;
    n_checks++; if (b2.rsp_valid_o !== 1'b0) $display("FAIL abort_rsp_valid_in_reset got %b want 0", b2.rsp_valid_o); else n_pass++;
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b2.rsp_valid_o !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL abort_no_response got %b want 0", seen); else n_pass++;
    txn2(1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat, os);
    model(1'b0, 32'h20, 32'h0, 3'b010, mrd, mer);
    n_checks++; if (rd !== 32'hCAFE_F00D) $display("FAIL abort_storage got %h want cafef00d", rd); else n_pass++;
    n_checks++; if (rd !== mrd) $display("FAIL abort_model got %h want %h", rd, mrd); else n_pass++;
  endtask

  task automatic test_back_to_back();
    vec_t q [8];
    logic [31:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    for (int i = 0; i < 4; i++) q[i] = '{1'b1, 32'(32'h40 + i * 4), d[i], 3'b010, 32'h0, 1'b0};
    for (int i = 0; i < 4; i++) q[4 + i] = '{1'b0, 32'(32'h4C - i * 4), 32'h0, 3'b010, d[3 - i], 1'b0};
    @(negedge clk);
    b1.req_valid_i  = 1'b1;
    b1.req_write_i  = q[0].wr;
    b1.req_addr_i   = q[0].a;
    b1.req_wdata_i  = q[0].wd;
    b1.req_funct3_i = q[0].f3;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (b1.req_ready_o !== 1'b1) $display("FAIL b2b%0d_ready got %b want 1", i, b1.req_ready_o); else n_pass++;
      @(negedge clk);
      n_checks++; if (b1.rsp_valid_o !== 1'b1) $display("FAIL b2b%0d_valid got %b want 1", i, b1.rsp_valid_o); else n_pass++;
      n_checks++; if (b1.rsp_rdata_o !== q[i].rd) $display("FAIL b2b%0d_rdata got %h want %h", i, b1.rsp_rdata_o, q[i].rd); else n_pass++;
      n_checks++; if (b1.rsp_err_o !== 1'b0) $display("FAIL b2b%0d_err got %b want 0", i, b1.rsp_err_o); else n_pass++;
      if (i < 7) begin
        b1.req_write_i  = q[i+1].wr;
        b1.req_addr_i   = q[i+1].a;
        b1.req_wdata_i  = q[i+1].wd;
        b1.req_funct3_i = q[i+1].f3;
      end else begin
        b1.req_valid_i = 1'b0;
      end
    end
    @(negedge clk);
    n_checks++; if (b1.rsp_valid_o !== 1'b0) $display("FAIL b2b_drain_valid got %b want 0", b1.rsp_valid_o); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    b2.req_valid_i = 1'b0; b2.req_write_i = 1'b0; b2.req_addr_i = '0; b2.req_wdata_i = '0; b2.req_funct3_i = '0;
    b1.req_valid_i = 1'b0; b1.req_write_i = 1'b0; b1.req_addr_i = '0; b1.req_wdata_i = '0; b1.req_funct3_i = '0;
    test_reset();
    test_directed();
    test_busy_ready();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end
endmodule
